pattern_stream_tx: RTL and testbench

//  Transmit side of the serial pattern-detector interface (valid_o/d_o bit stream).
//  - Accepts parallel words over a valid/ready handshake into a small FIFO.
//  - Serializes each word MSB-first, one bit per clock, with valid_o asserted.
//  - Sits upstream of the Mealy non-overlapping detector and drives its valid_i/d_i.

---
 rtl/pattern_stream_tx.sv | 211 +++++++++++++++++++++
 tb/tb_pattern_stream_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_stream_tx.sv
// Parallel-word to MSB-first serial stream (valid_o/d_o), buffered by a small FIFO; optional golden
// pattern counter under `PATTERN_COUNT_EN. Latency: word pushed at edge k shows its MSB after edge k+1.
// Backpressure: word_ready_o drops while the FIFO is full; words queued back-to-back stream with no gap.

module pattern_stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [W-1:0]               wdat,
    input  logic                       pop,
    output logic [W-1:0]               rdat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     cnt_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdat    = mem[rd_ptr];

    always_comb begin
        cnt_nxt = cnt;
        case ({push_ok, pop_ok})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= wdat;
    end
endmodule

module pattern_stream_tx #(
    parameter int               WORD_W     = 8,
    parameter int               FIFO_DEPTH = 4,
    parameter int               PAT_W      = 5,
    parameter logic [PAT_W-1:0] PATTERN    = 5'b10110,
    parameter int               CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              word_valid_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              word_ready_o,
    output logic              valid_o,
    output logic              d_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  expected_count_o
);
    localparam int BCW = $clog2(WORD_W);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WORD_W < 2 ||
        PAT_W < 1 || $bits(PATTERN) != PAT_W) begin : g_bad_param
        $error("pattern_stream_tx: illegal parameter set");
    end

    state_t                   state, state_nxt;
    logic [WORD_W-1:0]        shreg, shreg_nxt;
    logic [BCW-1:0]           bit_cnt, bit_cnt_nxt;
    logic                     valid_nxt;
    logic                     d_nxt;
    logic                     busy_nxt;
    logic                     load;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [WORD_W-1:0]        fifo_rdat;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt_nxt;

    assign word_ready_o = !fifo_full;

    pattern_stream_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (word_valid_i),
        .wdat    (word_i),
        .pop     (load),
        .rdat    (fifo_rdat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .cnt_nxt (fifo_cnt_nxt)
    );

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        valid_nxt   = valid_o;
        d_nxt       = d_o;
        load        = 1'b0;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                d_nxt     = 1'b0;
                load      = !fifo_empty;
            end
            SHIFT: begin
                if (bit_cnt != '0) begin
                    shreg_nxt   = shreg << 1;
                    d_nxt       = shreg[WORD_W-2];
                    bit_cnt_nxt = bit_cnt - 1'b1;
                    valid_nxt   = 1'b1;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    d_nxt     = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Loading straight from the last bit keeps the stream gap-free.
        if (load) begin
            shreg_nxt   = fifo_rdat;
            bit_cnt_nxt = LAST_BIT;
            valid_nxt   = 1'b1;
            d_nxt       = fifo_rdat[WORD_W-1];
            state_nxt   = SHIFT;
        end
        busy_nxt = (state_nxt == SHIFT) || (fifo_cnt_nxt != '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            valid_o <= 1'b0;
            d_o     <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            valid_o <= valid_nxt;
            d_o     <= d_nxt;
            busy_o  <= busy_nxt;
        end
    end

`ifdef PATTERN_COUNT_EN
    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] win, win_nxt;
    logic [FW-1:0]    fill, fill_nxt;
    logic             hit;
    logic [CNT_W-1:0] match_cnt;

    always_comb begin
        win_nxt  = {win[PAT_W-2:0], d_o};
        fill_nxt = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
        hit      = (fill_nxt == FW'(PAT_W)) && (win_nxt == PATTERN);
    end

    // Window restarts empty after a hit so matches never share bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win       <= '0;
            fill      <= '0;
            match_cnt <= '0;
        end else if (valid_o) begin
            if (hit) begin
                win  <= '0;
                fill <= '0;
                if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
            end else begin
                win  <= win_nxt;
                fill <= fill_nxt;
            end
        end
    end

    assign expected_count_o = match_cnt;
`else
    assign expected_count_o = '0;
`endif
endmodule

// File: tb/tb_pattern_stream_tx.sv
// Directed bench for pattern_stream_tx: table of single words plus hand-written multi-word sequences;
// a negedge monitor checks every emitted bit against the pushed words and runs a reference 10110 detector.
module tb_pattern_stream_tx;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              word_valid_i;
    logic [WORD_W-1:0] word_i;
    logic              word_ready_o;
    logic              valid_o;
    logic              d_o;
    logic              busy_o;
    logic [CNT_W-1:0]  expected_count_o;

    always #5 clk_i = ~clk_i;

    pattern_stream_tx dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .word_valid_i     (word_valid_i),
        .word_i           (word_i),
        .word_ready_o     (word_ready_o),
        .valid_o          (valid_o),
        .d_o              (d_o),
        .busy_o           (busy_o),
        .expected_count_o (expected_count_o)
    );

    int   n_vec  = 0;
    int   n_fail = 0;
    logic sb[$];
    int   run_len   = 0;
    int   last_run  = 0;
    int   emitted   = 0;
    int   kmp_st    = 0;
    int   model_cnt = 0;

    typedef struct {
        logic [WORD_W-1:0] word;
        int                cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cnt_exp(input int c);
`ifdef PATTERN_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // Stream monitor: bit-exact scoreboard, run length, and reference non-overlapping 10110 detector.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (valid_o) begin
                logic b;
                run_len++;
                emitted++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL extra_bit: d_o=%0b emitted with no word pending at %0t", d_o, $time);
                end else begin
                    b = sb.pop_front();
                    chk("stream_bit", d_o, b);
                end
                case (kmp_st)
                    0: kmp_st = d_o ? 1 : 0;
                    1: kmp_st = d_o ? 1 : 2;
                    2: kmp_st = d_o ? 3 : 0;
                    3: kmp_st = d_o ? 4 : 2;
                    default: begin
                        if (!d_o) begin
                            model_cnt++;
                            kmp_st = 0;
                        end else begin
                            kmp_st = 1;
                        end
                    end
                endcase
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
                chk("idle_d_low", d_o, 0);
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        word_valid_i = 1'b0;
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_d", d_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", word_ready_o, 1);
        chk("rst_count", expected_count_o, 0);
        sb.delete();
        run_len   = 0;
        last_run  = 0;
        emitted   = 0;
        kmp_st    = 0;
        model_cnt = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        int g = 0;
        word_valid_i = 1'b1;
        word_i       = w;
        while (!word_ready_o && g < 200) begin
            idle_cycle();
            g++;
        end
        if (!word_ready_o) begin
            n_vec++;
            n_fail++;
            $display("FAIL push_timeout: word %0h never accepted", w);
            word_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        for (int i = WORD_W - 1; i >= 0; i--) sb.push_back(w[i]);
        #1;
        word_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy_o || valid_o) && g < 400) begin
            idle_cycle();
            g++;
        end
        chk("drain_busy", busy_o, 0);
        @(negedge clk_i);
        idle_cycle();
        chk("all_bits_out", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   seen;
        int   sent;
        logic [WORD_W-1:0] w;

        tbl[0] = '{8'hB6, 1};
        tbl[1] = '{8'h2C, 1};
        tbl[2] = '{8'hFF, 0};
        tbl[3] = '{8'h00, 0};
        tbl[4] = '{8'h5A, 1};
        tbl[5] = '{8'h81, 0};

        word_i = '0;
        do_reset();

        // Single words from idle: latency, MSB first, 8-bit run, per-word count
        for (int i = 0; i < 6; i++) begin
            do_reset();
            w = tbl[i].word;
            push_word(w);
            chk("lat_valid_low", valid_o, 0);
            chk("lat_busy", busy_o, 1);
            idle_cycle();
            chk("msb_valid", valid_o, 1);
            chk("msb_d", d_o, w[WORD_W-1]);
            wait_idle();
            chk("word_run_len", last_run, 8);
            chk("word_count", expected_count_o, cnt_exp(tbl[i].cnt));
        end

        // Reset in the middle of a word
        do_reset();
        push_word(8'hB6);
        repeat (3) idle_cycle();
        chk("mid_word_valid", valid_o, 1);
        do_reset();
        seen = 0;
        repeat (12) begin
            idle_cycle();
            if (valid_o) seen++;
        end
        chk("post_rst_bits", seen, 0);
        chk("post_rst_busy", busy_o, 0);

        // Back-to-back words: 16 contiguous bits, two matches
        do_reset();
        push_word(8'hB6);
        push_word(8'h2C);
        wait_idle();
        chk("b2b_run_len", last_run, 16);
        chk("b2b_count", expected_count_o, cnt_exp(2));

        // Fill to full; a held word must not be taken while full
        do_reset();
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        push_word(8'h55);
        chk("full_ready", word_ready_o, 0);
        chk("full_busy", busy_o, 1);
        word_valid_i = 1'b1;
        word_i       = 8'hEE;
        repeat (2) idle_cycle();
        chk("full_ready_held", word_ready_o, 0);
        word_valid_i = 1'b0;
        wait_idle();
        chk("fill_run_len", last_run, 40);

        // Push on the exact edge the next word loads: occupancy stays at 1
        do_reset();
        push_word(8'hA5);
        push_word(8'h3C);
        repeat (7) idle_cycle();
        chk("pre_load_valid", valid_o, 1);
        push_word(8'hC3);
        chk("pp_ready_1", word_ready_o, 1);
        chk("pp_load_valid", valid_o, 1);
        push_word(8'h5A);
        push_word(8'h69);
        chk("pp_ready_3", word_ready_o, 1);
        push_word(8'h96);
        chk("pp_ready_full", word_ready_o, 0);
        wait_idle();
        chk("pp_run_len", last_run, 48);

        // Random traffic against the reference detector
        do_reset();
        sent = 0;
        while (sent < 600) begin
            if ($urandom_range(0, 2) != 0) begin
                w = WORD_W'($urandom);
                push_word(w);
                sent++;
            end else begin
                idle_cycle();
            end
        end
        wait_idle();
        chk("rand_bits_total", emitted, 600 * WORD_W);
        chk("rand_count", expected_count_o, cnt_exp(model_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
